// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared constants and types for the branch resolver
// Purpose: opcode/funct3 encodings, 2-bit counter values and FSM state enum
//          used by branch_resolver and branch_pht.
// Ports:   none (package).
package branch_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef enum logic {
    ST_IDLE,
    ST_FLUSH
  } state_e;

endpackage

// File: rtl/branch_pht.sv
// rtl/branch_pht.sv - pattern history table of 2-bit saturating counters
// Purpose: counter array with one combinational read port and one
//          synchronous train port (saturating increment/decrement).
// Ports:
//   clk_i        clock
//   rst_ni       synchronous active-low reset, all counters -> CTR_WNT
//   rd_idx_i     read index
//   rd_ctr_o     counter at rd_idx_i (pre-update value on same-cycle write)
//   wr_en_i      train enable
//   wr_idx_i     train index
//   wr_taken_i   1: increment, 0: decrement
module branch_pht
  import branch_pkg::*;
#(
  parameter int ENTRIES = 64,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_ctr_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  logic [1:0] ctr_q [ENTRIES];
  logic [1:0] wr_old;
  logic [1:0] wr_ctr_d;

  assign rd_ctr_o = ctr_q[rd_idx_i];
  assign wr_old   = ctr_q[wr_idx_i];

  always_comb begin
    wr_ctr_d = wr_old;
    if (wr_taken_i) begin
      if (wr_old != CTR_ST) wr_ctr_d = wr_old + 2'd1;
    end else begin
      if (wr_old != CTR_SNT) wr_ctr_d = wr_old - 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_WNT;
    end else if (wr_en_i) begin
      ctr_q[wr_idx_i] <= wr_ctr_d;
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - ID-stage branch resolution, redirect/flush and PHT owner
// Purpose: evaluates conditional branches in ID, compares with the IF
//          prediction, issues a registered redirect + multi-cycle flush on a
//          mispredict, and trains the PHT that IF reads.
// Optional: BRANCH_RESOLVER_STATS_EN adds stat_branches / stat_mispredicts.
// Ports:
//   clk, rst (sync active-low), stall
//   if_pc -> pred_taken               IF-side PHT lookup (combinational)
//   id_valid, id_pc, id_instr,
//   id_rs1_val, id_rs2_val,
//   id_predicted_taken -> branch_taken  ID-side resolution (combinational)
//   redirect, redirect_pc, flush      registered pipeline control
//   stat_branches, stat_mispredicts   32-bit counters (optional)
module branch_resolver
  import branch_pkg::*;
#(
  parameter int PHT_ENTRIES  = 64,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [63:0] if_pc,
  output logic        pred_taken,
  input  logic        id_valid,
  input  logic [63:0] id_pc,
  input  logic [31:0] id_instr,
  input  logic [63:0] id_rs1_val,
  input  logic [63:0] id_rs2_val,
  input  logic        id_predicted_taken,
  output logic        branch_taken,
  output logic        redirect,
  output logic [63:0] redirect_pc,
  output logic        flush
`ifdef BRANCH_RESOLVER_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int         IDX_W      = $clog2(PHT_ENTRIES);
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [63:0] imm;
  logic [63:0] target;
  logic [63:0] fallthrough;
  logic        f3_ok;
  logic        cond;
  logic        is_branch;
  logic        resolve;
  logic        mispredict;
  logic [1:0]  rd_ctr;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        redirect_q, redirect_d;
  logic [63:0] redirect_pc_q, redirect_pc_d;
  logic        flush_q, flush_d;

  // Register-index fields and PC bits outside the PHT index are not needed.
  logic unused_bits;
  assign unused_bits = ^{if_pc[63:IDX_W+2], if_pc[1:0], id_instr[24:15]};

  assign opcode      = id_instr[6:0];
  assign funct3      = id_instr[14:12];
  assign imm         = {{51{id_instr[31]}}, id_instr[31], id_instr[7],
                        id_instr[30:25], id_instr[11:8], 1'b0};
  assign target      = id_pc + imm;
  assign fallthrough = id_pc + 64'd4;

  always_comb begin
    f3_ok = 1'b1;
    cond  = 1'b0;
    unique case (funct3)
      F3_BEQ:  cond = (id_rs1_val == id_rs2_val);
      F3_BNE:  cond = (id_rs1_val != id_rs2_val);
      F3_BLT:  cond = ($signed(id_rs1_val) <  $signed(id_rs2_val));
      F3_BGE:  cond = ($signed(id_rs1_val) >= $signed(id_rs2_val));
      F3_BLTU: cond = (id_rs1_val <  id_rs2_val);
      F3_BGEU: cond = (id_rs1_val >= id_rs2_val);
      default: f3_ok = 1'b0;
    endcase
  end

  assign is_branch    = id_valid && (opcode == OPC_BRANCH) && f3_ok;
  assign branch_taken = is_branch && cond;
  // Resolution (and training) only happens in IDLE with the pipe moving.
  assign resolve      = is_branch && !stall && (state_q == ST_IDLE);
  assign mispredict   = resolve && (branch_taken != id_predicted_taken);

  branch_pht #(
    .ENTRIES (PHT_ENTRIES)
  ) u_pht (
    .clk_i      (clk),
    .rst_ni     (rst),
    .rd_idx_i   (if_pc[IDX_W+1:2]),
    .rd_ctr_o   (rd_ctr),
    .wr_en_i    (resolve),
    .wr_idx_i   (id_pc[IDX_W+1:2]),
    .wr_taken_i (branch_taken)
  );

  assign pred_taken = rd_ctr[1];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mispredict) begin
          state_d       = ST_FLUSH;
          cnt_d         = FLUSH_INIT;
          redirect_d    = 1'b1;
          redirect_pc_d = branch_taken ? target : fallthrough;
        end
      end
      ST_FLUSH: begin
        // Counts down regardless of stall; the cycle holding 1 is the last.
        if (cnt_q <= 3'd1) begin
          cnt_d   = 3'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
    flush_d = (state_d == ST_FLUSH);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 3'd0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= 64'd0;
      flush_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      flush_q       <= flush_d;
    end
  end

  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign flush       = flush_q;

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] stat_br_q;
  logic [31:0] stat_mp_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_br_q <= 32'd0;
      stat_mp_q <= 32'd0;
    end else begin
      if (resolve)    stat_br_q <= stat_br_q + 32'd1;
      if (mispredict) stat_mp_q <= stat_mp_q + 32'd1;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - scoreboard testbench for branch_resolver
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [63:0] if_pc;
  logic        pred_taken;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_instr;
  logic [63:0] id_rs1_val;
  logic [63:0] id_rs2_val;
  logic        id_predicted_taken;
  logic        branch_taken;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        flush;
`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q [$];
  logic [63:0] exp_pc;

  always #5 clk = ~clk;

  branch_resolver #(
    .PHT_ENTRIES  (64),
    .FLUSH_CYCLES (3)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .stall              (stall),
    .if_pc              (if_pc),
    .pred_taken         (pred_taken),
    .id_valid           (id_valid),
    .id_pc              (id_pc),
    .id_instr           (id_instr),
    .id_rs1_val         (id_rs1_val),
    .id_rs2_val         (id_rs2_val),
    .id_predicted_taken (id_predicted_taken),
    .branch_taken       (branch_taken),
    .redirect           (redirect),
    .redirect_pc        (redirect_pc),
    .flush              (flush)
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    .stat_branches      (stat_branches),
    .stat_mispredicts   (stat_mispredicts)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_br(input logic [63:0] pc, input logic [2:0] f3, input logic [12:0] imm,
                        input logic [63:0] a, input logic [63:0] b, input logic pred);
    id_valid           = 1'b1;
    id_pc              = pc;
    id_instr           = enc_b(f3, imm);
    id_rs1_val         = a;
    id_rs2_val         = b;
    id_predicted_taken = pred;
  endtask

  // Monitor: every redirect must match the oldest expected redirect target.
  always @(negedge clk) begin
    if (redirect === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_redirect actual=1 required=0 pc=%h", redirect_pc);
      end else begin
        exp_pc = exp_q.pop_front();
        chk("redirect_pc", redirect_pc, exp_pc);
        chk("flush_with_redirect", {63'd0, flush}, 64'd1);
      end
    end
  end

  initial begin
    rst = 1'b0; stall = 1'b0; if_pc = 64'h1000;
    id_valid = 1'b0; id_pc = '0; id_instr = '0;
    id_rs1_val = '0; id_rs2_val = '0; id_predicted_taken = 1'b0;
    tick; tick;
    chk("reset_pred_taken", {63'd0, pred_taken}, 64'd0);
    chk("reset_redirect", {63'd0, redirect}, 64'd0);
    chk("reset_flush", {63'd0, flush}, 64'd0);
    chk("reset_redirect_pc", redirect_pc, 64'd0);
    chk("reset_branch_taken", {63'd0, branch_taken}, 64'd0);
    rst = 1'b1;
    tick;

    // BEQ taken, predicted not-taken: redirect to 0x1010, flush 3 cycles.
    set_br(64'h1000, 3'b000, 13'd16, 64'd5, 64'd5, 1'b0);
    if_pc = 64'h1000;
    #1;
    chk("beq_taken", {63'd0, branch_taken}, 64'd1);
    chk("same_cycle_pred_old", {63'd0, pred_taken}, 64'd0);
    exp_q.push_back(64'h1010);
    tick;
    id_valid = 1'b0;
    chk("beq_flush_c1", {63'd0, flush}, 64'd1);
    chk("beq_pht_trained", {63'd0, pred_taken}, 64'd1);
    tick;
    chk("beq_redirect_once", {63'd0, redirect}, 64'd0);
    chk("beq_flush_c2", {63'd0, flush}, 64'd1);
    tick;
    chk("beq_flush_c3", {63'd0, flush}, 64'd1);
    tick;
    chk("beq_flush_end", {63'd0, flush}, 64'd0);

    // BNE not taken twice, predicted correctly: counter 01 -> 00 -> 00.
    set_br(64'h2010, 3'b001, 13'd16, 64'd7, 64'd7, 1'b0);
    if_pc = 64'h2010;
    #1;
    chk("bne_not_taken", {63'd0, branch_taken}, 64'd0);
    tick;
    tick;
    id_valid = 1'b0;
    #1;
    chk("bne_no_redirect", {63'd0, redirect}, 64'd0);
    chk("bne_pred_after2", {63'd0, pred_taken}, 64'd0);
    // One taken: 00 -> 01 stays not-taken only if it saturated at 00.
    set_br(64'h2010, 3'b001, 13'd16, 64'd7, 64'd8, 1'b1);
    #1;
    chk("bne_taken", {63'd0, branch_taken}, 64'd1);
    tick;
    id_valid = 1'b0;
    #1;
    chk("bne_saturated", {63'd0, pred_taken}, 64'd0);

    // BLT -1 < 1 taken (correct); BLTU 0xFFFF.. < 1 false (mispredict).
    set_br(64'h3020, 3'b100, 13'd16, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    #1;
    chk("blt_taken", {63'd0, branch_taken}, 64'd1);
    tick;
    set_br(64'h3024, 3'b110, 13'd16, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    #1;
    chk("bltu_not_taken", {63'd0, branch_taken}, 64'd0);
    exp_q.push_back(64'h3028);
    tick;
    id_valid = 1'b0;
    if_pc = 64'h3020;
    #1;
    chk("bltu_flush", {63'd0, flush}, 64'd1);
    chk("blt_pht_trained", {63'd0, pred_taken}, 64'd1);
    tick; tick; tick;
    chk("bltu_flush_end", {63'd0, flush}, 64'd0);

    // funct3 010 is not a branch.
    set_br(64'h3030, 3'b010, 13'd16, 64'd1, 64'd1, 1'b1);
    #1;
    chk("f3_010_not_branch", {63'd0, branch_taken}, 64'd0);
    tick;
    id_valid = 1'b0;
    chk("f3_010_no_flush", {63'd0, flush}, 64'd0);

    // BGE taken with negative offset held under stall, then released.
    set_br(64'h4040, 3'b101, 13'h1FF8, 64'd1, 64'd1, 1'b0);
    stall = 1'b1;
    #1;
    chk("bge_taken", {63'd0, branch_taken}, 64'd1);
    tick;
    chk("stall_no_flush", {63'd0, flush}, 64'd0);
    tick;
    chk("stall_no_redirect", {63'd0, redirect}, 64'd0);
    stall = 1'b0;
    exp_q.push_back(64'h4038);
    tick;
    // FLUSH: a mispredicting branch in ID with stall toggling is ignored.
    set_br(64'h5050, 3'b000, 13'd16, 64'd3, 64'd3, 1'b0);
    stall = 1'b0;
    chk("sflush_c1", {63'd0, flush}, 64'd1);
    tick;
    stall = 1'b1;
    chk("sflush_c2", {63'd0, flush}, 64'd1);
    tick;
    stall = 1'b0;
    chk("sflush_c3", {63'd0, flush}, 64'd1);
    tick;
    id_valid = 1'b0;
    chk("sflush_end", {63'd0, flush}, 64'd0);
    if_pc = 64'h5050;
    #1;
    chk("flush_no_training", {63'd0, pred_taken}, 64'd0);

    // Target wraps modulo 2^64.
    set_br(64'hFFFF_FFFF_FFFF_FFF0, 3'b000, 13'd32, 64'd9, 64'd9, 1'b0);
    exp_q.push_back(64'h10);
    tick;
    id_valid = 1'b0;
    tick; tick; tick;
    chk("wrap_flush_end", {63'd0, flush}, 64'd0);

    // Reset in the cycle after a mispredict.
    set_br(64'h6060, 3'b000, 13'd16, 64'd1, 64'd1, 1'b0);
    exp_q.push_back(64'h6070);
    tick;
    id_valid = 1'b0;
    chk("rst_pre_redirect", {63'd0, redirect}, 64'd1);
    rst = 1'b0;
    tick;
    chk("rst_flush", {63'd0, flush}, 64'd0);
    chk("rst_redirect", {63'd0, redirect}, 64'd0);
    chk("rst_redirect_pc", redirect_pc, 64'd0);
    if_pc = 64'h1000;
    #1;
    chk("rst_pht_1000", {63'd0, pred_taken}, 64'd0);
    if_pc = 64'h3020;
    #1;
    chk("rst_pht_3020", {63'd0, pred_taken}, 64'd0);
    rst = 1'b1;
    tick; tick;
    chk("post_rst_flush", {63'd0, flush}, 64'd0);
    chk("post_rst_redirect", {63'd0, redirect}, 64'd0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
